// File: rtl/dab_tps_modulator.sv
`default_nettype none
// ============================================================================
// Module      : dab_tps_modulator
// Description : N-bridge triple-phase-shift modulator. A phase accumulator
//               sets the switching period; every bridge emits a centred
//               three-level quasi-square wave with its own pulse width and
//               phase offset relative to bridge 0. Width/phase updates are
//               double-buffered and applied atomically at period boundaries.
//               Optional dead-time on direct +V/-V reversals is enabled by
//               defining DAB_TPS_DEADTIME_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dab_tps_modulator #(
    parameter int N_BR     = 2,
    parameter int ANG_W    = 9,
    parameter int PHASE_W  = 16,
    parameter int DEAD_CYC = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      sync,
    input  logic [PHASE_W-1:0]        phase_inc,
    input  logic [N_BR*(ANG_W-1)-1:0] t_flat,
    input  logic [N_BR*ANG_W-1:0]     phi_flat,
    input  logic                      load,
    output logic                      load_pending,
    output logic [2*N_BR-1:0]         v_flat,
    output logic                      trigger,
    output logic [ANG_W-1:0]          theta
);

    localparam int c_TW = ANG_W - 1;
    localparam logic [ANG_W-1:0] c_HALF = {1'b1, {(ANG_W-1){1'b0}}};

    logic [PHASE_W-1:0]     r_acc;
    logic                   r_sync_d;
    logic                   r_trig;
    logic                   r_pend;
    logic [N_BR*c_TW-1:0]   r_sh_t;
    logic [N_BR*c_TW-1:0]   r_act_t;
    logic [N_BR*ANG_W-1:0]  r_sh_phi;
    logic [N_BR*ANG_W-1:0]  r_act_phi;

    logic [PHASE_W:0]       w_sum;
    logic                   w_rise;
    logic                   w_bnd;

    // Carry out of the accumulator add marks a natural period wrap
    assign w_sum  = {1'b0, r_acc} + {1'b0, phase_inc};
    assign w_rise = sync & ~r_sync_d;
    // Wrap and sync together still form a single boundary
    assign w_bnd  = ce & (w_sum[PHASE_W] | w_rise);

    assign theta        = r_acc[PHASE_W-1 -: ANG_W];
    assign trigger      = r_trig;
    assign load_pending = r_pend;

    // Phase accumulator, sync edge tracking and period-start pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc    <= '0;
            r_sync_d <= 1'b0;
            r_trig   <= 1'b0;
        end else begin
            r_sync_d <= sync;
            r_trig   <= w_bnd;
            if (ce) begin
                r_acc <= w_rise ? '0 : w_sum[PHASE_W-1:0];
            end
        end
    end

    // Double-buffered width/phase registers; a load in a boundary cycle wins
    // and defers the transfer to the following boundary
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh_t    <= '0;
            r_sh_phi  <= '0;
            r_act_t   <= '0;
            r_act_phi <= '0;
            r_pend    <= 1'b0;
        end else if (load) begin
            r_sh_t   <= t_flat;
            r_sh_phi <= phi_flat;
            r_pend   <= 1'b1;
        end else if (w_bnd && r_pend) begin
            r_act_t   <= r_sh_t;
            r_act_phi <= r_sh_phi;
            r_pend    <= 1'b0;
        end
    end

`ifdef DAB_TPS_DEADTIME_EN
    localparam int c_CW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [c_CW-1:0] c_HOLD = c_CW'(DEAD_CYC - 1);
`endif

    for (genvar k = 0; k < N_BR; k++) begin : g_bridge
        logic [c_TW-1:0]  w_t;
        logic [ANG_W-1:0] w_phi;
        logic [ANG_W-1:0] w_ang;
        logic [ANG_W-1:0] w_lo;
        logic [ANG_W-1:0] w_hi;
        logic [ANG_W-1:0] w_rel;
        logic             w_in;
        logic [1:0]       w_raw;
        logic [1:0]       r_vb;

        assign w_t   = r_act_t[k*c_TW +: c_TW];
        // Bridge 0 is the phase reference
        assign w_phi = (k == 0) ? '0 : r_act_phi[k*ANG_W +: ANG_W];
        assign w_ang = theta - w_phi;
        // Centred pulse window [lo, hi) within each half period
        assign w_lo  = (c_HALF - {1'b0, w_t}) >> 1;
        assign w_hi  = w_lo + {1'b0, w_t};
        // Position within the current half period (a or a-H)
        assign w_rel = {1'b0, w_ang[ANG_W-2:0]};
        assign w_in  = (w_rel >= w_lo) && (w_rel < w_hi);
        assign w_raw = w_in ? (w_ang[ANG_W-1] ? 2'b10 : 2'b01) : 2'b00;

`ifdef DAB_TPS_DEADTIME_EN
        logic [1:0]      r_prev;
        logic [c_CW-1:0] r_cnt;
        logic            w_rev;

        // Both states non-zero and different: a direct +V <-> -V step
        assign w_rev = (w_raw ^ r_prev) == 2'b11;

        // Output register with dead-time insertion on direct reversals
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_prev <= 2'b00;
                r_cnt  <= '0;
                r_vb   <= 2'b00;
            end else if (ce) begin
                r_prev <= w_raw;
                if (w_rev) begin
                    r_cnt <= c_HOLD;
                    r_vb  <= 2'b00;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                    r_vb  <= 2'b00;
                end else begin
                    r_vb <= w_raw;
                end
            end else begin
                r_vb <= 2'b00;
            end
        end
`else
        // Output register; forced to zero state while the clock enable is low
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_vb <= 2'b00;
            end else begin
                r_vb <= ce ? w_raw : 2'b00;
            end
        end
`endif

        assign v_flat[2*k +: 2] = r_vb;
    end

endmodule
`default_nettype wire
